// File: rtl/ps2_host_transmitter.sv
// Host-to-device PS/2 command transmitter: inhibit, request-to-send, 11-clock frame, ACK, completion pulse.
// Optional macro PS2_TX_ACK_CHECK_EN: a high ACK sample ends the transfer with Error instead of Done.
module ps2_host_transmitter #(
    parameter int unsigned INHIBIT_CYCLES = 5000,
    parameter int unsigned TIMEOUT_CYCLES = 750000
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic [7:0] Data_in,
    input  logic       Send,
    input  logic       KB_Clock_in,
    input  logic       KB_Data_in,
    output logic       KB_Clock_oe,
    output logic       KB_Data_oe,
    output logic       Busy,
    output logic       Done,
    output logic       Error
);

    localparam int unsigned CNT_MAX = (TIMEOUT_CYCLES > INHIBIT_CYCLES) ? TIMEOUT_CYCLES : INHIBIT_CYCLES;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] INH_LAST = CNT_W'(INHIBIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] INHIBIT   = 3'd1;
    localparam logic [2:0] REQ       = 3'd2;
    localparam logic [2:0] SHIFT     = 3'd3;
    localparam logic [2:0] ACK       = 3'd4;
    localparam logic [2:0] WAIT_IDLE = 3'd5;
    localparam logic [2:0] DONE      = 3'd6;
    localparam logic [2:0] ERROR     = 3'd7;

    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       bit_q, bit_d;
    logic [9:0]       frame_q, frame_d;
    logic [1:0]       clk_sync_q, dat_sync_q;
    logic             clk_prev_q;
    logic             clk_oe_q, clk_oe_d;
    logic             dat_oe_q, dat_oe_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             error_q, error_d;
    logic             kb_fall;
    logic             timed_c;

    assign kb_fall     = clk_prev_q & ~clk_sync_q[1];
    assign KB_Clock_oe = clk_oe_q;
    assign KB_Data_oe  = dat_oe_q;
    assign Busy        = busy_q;
    assign Done        = done_q;
    assign Error       = error_q;

    // Synchronizers idle high so reset never manufactures a falling edge.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            clk_sync_q <= 2'b11;
            dat_sync_q <= 2'b11;
            clk_prev_q <= 1'b1;
        end else begin
            clk_sync_q <= {clk_sync_q[0], KB_Clock_in};
            dat_sync_q <= {dat_sync_q[0], KB_Data_in};
            clk_prev_q <= clk_sync_q[1];
        end
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            bit_q    <= '0;
            frame_q  <= '0;
            clk_oe_q <= 1'b0;
            dat_oe_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            error_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            bit_q    <= bit_d;
            frame_q  <= frame_d;
            clk_oe_q <= clk_oe_d;
            dat_oe_q <= dat_oe_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            error_q  <= error_d;
        end
    end

    // Outputs are computed for the next state so they line up with it once registered.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        bit_d    = bit_q;
        frame_d  = frame_q;
        clk_oe_d = 1'b0;
        dat_oe_d = 1'b0;
        done_d   = 1'b0;
        error_d  = 1'b0;
        timed_c  = (state_q == REQ) || (state_q == SHIFT) || (state_q == ACK) || (state_q == WAIT_IDLE);

        case (state_q)
            IDLE: begin
                if (Send) begin
                    frame_d  = {1'b1, ~^Data_in, Data_in};
                    cnt_d    = '0;
                    bit_d    = '0;
                    state_d  = INHIBIT;
                    clk_oe_d = 1'b1;
                    dat_oe_d = (INH_LAST == '0);
                end
            end
            INHIBIT: begin
                if (cnt_q == INH_LAST) begin
                    state_d  = REQ;
                    cnt_d    = '0;
                    dat_oe_d = 1'b1;
                end else begin
                    cnt_d    = cnt_q + CNT_W'(1);
                    clk_oe_d = 1'b1;
                    dat_oe_d = (cnt_d == INH_LAST);
                end
            end
            REQ: begin
                dat_oe_d = 1'b1;
                if (kb_fall) begin
                    dat_oe_d = ~frame_q[0];
                    bit_d    = 4'd1;
                    state_d  = SHIFT;
                end
            end
            SHIFT: begin
                dat_oe_d = dat_oe_q;
                if (kb_fall) begin
                    frame_d  = {1'b1, frame_q[9:1]};
                    bit_d    = bit_q + 4'd1;
                    dat_oe_d = ~frame_q[1];
                    if (bit_q == 4'd9) begin
                        dat_oe_d = 1'b0;
                        state_d  = ACK;
                    end
                end
            end
            ACK: begin
                if (kb_fall) begin
`ifdef PS2_TX_ACK_CHECK_EN
                    if (dat_sync_q[1]) begin
                        state_d = ERROR;
                        error_d = 1'b1;
                    end else begin
                        state_d = WAIT_IDLE;
                    end
`else
                    state_d = WAIT_IDLE;
`endif
                end
            end
            WAIT_IDLE: begin
                if (clk_sync_q[1] && dat_sync_q[1]) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            ERROR:   state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Timeout overrides everything and releases the lines on the same edge.
        if (timed_c) begin
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == TO_LAST) begin
                state_d  = ERROR;
                clk_oe_d = 1'b0;
                dat_oe_d = 1'b0;
                done_d   = 1'b0;
                error_d  = 1'b1;
            end
        end

        busy_d = (state_d != IDLE);
    end

endmodule

// File: tb/tb_ps2_host_transmitter.sv
// Directed bench for ps2_host_transmitter with a behavioural PS/2 device and a frame/outcome scoreboard.
module tb_ps2_host_transmitter;

    localparam int unsigned INH  = 50;
    localparam int unsigned TO   = 3000;
    localparam int          HALF = 20;
    localparam byte O_NONE = 8'd0;
    localparam byte O_DONE = 8'd1;
    localparam byte O_ERR  = 8'd2;
`ifdef PS2_TX_ACK_CHECK_EN
    localparam byte NACK_OUT = O_ERR;
`else
    localparam byte NACK_OUT = O_DONE;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] Data_in;
    logic       Send;
    logic       dev_clk = 1'b1;
    logic       dev_dat = 1'b1;
    logic       kb_clk, kb_dat;
    logic       KB_Clock_oe, KB_Data_oe, Busy, Done, Error;

    assign kb_clk = dev_clk & ~KB_Clock_oe;
    assign kb_dat = dev_dat & ~KB_Data_oe;

    always #5 clk = ~clk;

    ps2_host_transmitter #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TO)) dut (
        .Clock(clk), .Reset(rst), .Data_in(Data_in), .Send(Send),
        .KB_Clock_in(kb_clk), .KB_Data_in(kb_dat),
        .KB_Clock_oe(KB_Clock_oe), .KB_Data_oe(KB_Data_oe),
        .Busy(Busy), .Done(Done), .Error(Error)
    );

    int total = 0;
    int bad = 0;
    int done_cnt = 0, err_cnt = 0, both_cnt = 0;
    int inh_only = 0, inh_start = 0;
    int base_done = 0, base_err = 0;
    logic [9:0] exp_frame_q[$];
    byte        exp_out_q[$];
    logic [9:0] rx;
    logic [9:0] want_frame;
    int         w, k, busy_seen;
    logic [7:0] mid_byte;

    always @(negedge clk) begin
        if (Done) done_cnt++;
        if (Error) err_cnt++;
        if (Done && Error) both_cnt++;
        if (KB_Clock_oe) begin
            if (KB_Data_oe) inh_start++;
            else inh_only++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [9:0] frame_of(input logic [7:0] b);
        return {1'b1, ~^b, b};
    endfunction

    task automatic do_send(input logic [7:0] b, input bit push, input byte outc);
        @(negedge clk);
        inh_only  = 0;
        inh_start = 0;
        base_done = done_cnt;
        base_err  = err_cnt;
        Data_in   = b;
        Send      = 1'b1;
        if (push) begin
            exp_frame_q.push_back(frame_of(b));
            exp_out_q.push_back(outc);
        end
        @(negedge clk);
        Send    = 1'b0;
        Data_in = 8'h00;
        chk("busy_t1", 32'(Busy), 32'd1);
        chk("clkoe_t1", 32'(KB_Clock_oe), 32'd1);
    endtask

    // Device: waits for request-to-send, then generates n clocks sampling data on rising edges.
    task automatic dev_clocks(input int n, input logic ack, output logic [9:0] r);
        int ww;
        r  = '0;
        ww = 0;
        while (!(KB_Data_oe && !KB_Clock_oe) && ww < 2000) begin
            @(negedge clk);
            ww++;
        end
        chk("req_seen", 32'(KB_Data_oe & ~KB_Clock_oe), 32'd1);
        if (!(KB_Data_oe && !KB_Clock_oe)) return;
        repeat (10) @(negedge clk);
        for (int i = 1; i <= n; i++) begin
            dev_clk = 1'b0;
            repeat (HALF) @(negedge clk);
            dev_clk = 1'b1;
            if (i <= 10) r[i-1] = kb_dat;
            if (i == 10) begin
                repeat (5) @(negedge clk);
                dev_dat = ack;
                repeat (HALF - 5) @(negedge clk);
            end else begin
                if (i == 11) dev_dat = 1'b1;
                repeat (HALF) @(negedge clk);
            end
        end
    endtask

    task automatic check_frame(input string tag, input logic [9:0] r);
        logic [9:0] want;
        want = (exp_frame_q.size() > 0) ? exp_frame_q.pop_front() : 10'h000;
        chk({tag, "_frame"}, 32'(r), 32'(want));
    endtask

    task automatic finish_xfer(input string tag);
        int  ww;
        byte got, want;
        ww = 0;
        while ((done_cnt + err_cnt) == (base_done + base_err) && ww < 1000) begin
            @(negedge clk);
            ww++;
        end
        repeat (20) @(negedge clk);
        got  = (done_cnt != base_done) ? O_DONE : ((err_cnt != base_err) ? O_ERR : O_NONE);
        want = (exp_out_q.size() > 0) ? exp_out_q.pop_front() : O_NONE;
        chk({tag, "_outcome"}, 32'(got), 32'(want));
        chk({tag, "_pulses"}, 32'((done_cnt - base_done) + (err_cnt - base_err)), 32'd1);
        chk({tag, "_idle"}, 32'({Busy, KB_Clock_oe, KB_Data_oe}), 32'd0);
    endtask

    initial begin
        rst     = 1'b1;
        Send    = 1'b0;
        Data_in = 8'h00;
        repeat (3) @(negedge clk);
        chk("reset_outs", 32'({KB_Clock_oe, KB_Data_oe, Busy, Done, Error}), 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("post_reset_outs", 32'({KB_Clock_oe, KB_Data_oe, Busy, Done, Error}), 32'd0);

        // 0xED with ACK
        do_send(8'hED, 1'b1, O_DONE);
        dev_clocks(11, 1'b0, rx);
        check_frame("ed", rx);
        chk("ed_parity_bit", 32'(rx[8]), 32'd1);
        chk("ed_inhibit_len", 32'(inh_only), 32'(INH - 1));
        chk("ed_start_overlap", 32'(inh_start), 32'd1);
        finish_xfer("ed");

        // 0xFF with ACK
        do_send(8'hFF, 1'b1, O_DONE);
        dev_clocks(11, 1'b0, rx);
        check_frame("ff", rx);
        chk("ff_inhibit_len", 32'(inh_only), 32'(INH - 1));
        chk("ff_start_overlap", 32'(inh_start), 32'd1);
        finish_xfer("ff");

        // device never clocks
        do_send(8'h55, 1'b0, O_NONE);
        w = 0;
        while (!(KB_Data_oe && !KB_Clock_oe) && w < 200) begin
            @(negedge clk);
            w++;
        end
        chk("to_req_seen", 32'(KB_Data_oe & ~KB_Clock_oe), 32'd1);
        k = 0;
        while (!Error && k < int'(TO) + 100) begin
            @(negedge clk);
            k++;
        end
        chk("to_cycles", 32'(k), 32'(TO));
        chk("to_lines_released", 32'({KB_Clock_oe, KB_Data_oe}), 32'd0);
        chk("to_no_done", 32'(done_cnt - base_done), 32'd0);
        repeat (5) @(negedge clk);
        chk("to_busy_low", 32'(Busy), 32'd0);

        // missing ACK
        do_send(8'hF4, 1'b1, NACK_OUT);
        dev_clocks(11, 1'b1, rx);
        check_frame("nack", rx);
        finish_xfer("nack");

        // reset while bit 4 of 0xF3 is on the bus
        mid_byte = 8'hF3;
        do_send(mid_byte, 1'b0, O_NONE);
        dev_clocks(4, 1'b0, rx);
        chk("rst_low_nibble", 32'(rx[3:0]), 32'(mid_byte[3:0]));
        dev_clk = 1'b0;
        repeat (5) @(negedge clk);
        chk("rst_bit4_on_bus", 32'({Busy, KB_Data_oe}), 32'({1'b1, ~mid_byte[4]}));
        base_done = done_cnt;
        base_err  = err_cnt;
        #2 rst = 1'b1;
        #1 chk("rst_async_release", 32'({KB_Clock_oe, KB_Data_oe, Busy}), 32'd0);
        repeat (3) @(negedge clk);
        dev_clk = 1'b1;
        rst = 1'b0;
        repeat (50) @(negedge clk);
        chk("rst_no_pulses", 32'((done_cnt - base_done) + (err_cnt - base_err)), 32'd0);
        chk("rst_idle", 32'({Busy, KB_Clock_oe, KB_Data_oe}), 32'd0);
        do_send(mid_byte, 1'b1, O_DONE);
        dev_clocks(11, 1'b0, rx);
        check_frame("f3", rx);
        finish_xfer("f3");

        // Send pulses while busy are ignored
        do_send(8'hA5, 1'b1, O_DONE);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            Data_in = 8'h00;
            Send    = 1'b1;
            @(negedge clk);
            Send    = 1'b0;
        end
        dev_clocks(11, 1'b0, rx);
        check_frame("a5", rx);
        finish_xfer("a5");
        busy_seen = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (Busy) busy_seen++;
        end
        chk("a5_no_restart", 32'(busy_seen), 32'd0);
        chk("scoreboard_empty", 32'(exp_frame_q.size() + exp_out_q.size()), 32'd0);
        chk("done_error_exclusive", 32'(both_cnt), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
